// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with the carry chain split into
// STAGES registered segments and valid/ready flow control. Define ADDSUB_SAT_EN to clamp on signed overflow.
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;

    typedef logic [WIDTH-1:0] word_t;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    word_t             a_q [STAGES];
    word_t             a_d [STAGES];
    word_t             b_q [STAGES];
    word_t             b_d [STAGES];
    word_t             s_q [STAGES];
    word_t             s_d [STAGES];
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;

    // Load chain, per-segment add and last-stage flag/clamp computation.
    always_comb begin
        logic [STAGES-1:0] ld;
        word_t             src_a;
        word_t             src_b;
        word_t             src_s;
        word_t             raw;
        logic              src_c;
        logic              src_v;
        logic              ovf_s;
        logic [SEG:0]      seg;
        int                prev;

        v_d    = v_q;
        c_d    = c_q;
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        src_a  = '0;
        src_b  = '0;
        src_s  = '0;
        raw    = '0;
        src_c  = 1'b0;
        src_v  = 1'b0;
        ovf_s  = 1'b0;
        seg    = '0;
        prev   = 0;

        // A stage may load when empty or when everything downstream moves.
        ld[STAGES-1] = ~v_q[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld[k] = ~v_q[k] | ld[k+1];
        end
        in_ready = ld[0];

        for (int k = 0; k < STAGES; k++) begin
            prev = (k > 0) ? (k - 1) : 0;
            if (k == 0) begin
                src_a = a;
                src_b = sub ? ~b : b;
                src_s = '0;
                src_c = sub;
                src_v = in_valid;
            end else begin
                src_a = a_q[prev];
                src_b = b_q[prev];
                src_s = s_q[prev];
                src_c = c_q[prev];
                src_v = v_q[prev];
            end

            seg = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
                + {{SEG{1'b0}}, src_c};
            raw = src_s;
            raw[k*SEG +: SEG] = seg[SEG-1:0];

            if (ld[k]) begin
                v_d[k] = src_v;
                if (src_v) begin
                    a_d[k] = src_a;
                    b_d[k] = src_b;
                    c_d[k] = seg[SEG];
                    if (k == STAGES - 1) begin
                        ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                (raw[WIDTH-1] != src_a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
                        if (ovf_s) begin
                            raw = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
                        end else begin
                            raw = raw;
                        end
`endif
                        ovf_d  = ovf_s;
                        zero_d = ~|raw;
                    end else begin
                        ovf_d  = ovf_q;
                        zero_d = zero_q;
                    end
                    s_d[k] = raw;
                end else begin
                    s_d[k] = s_q[k];
                end
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Pipeline register ranks with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            s_q    <= '{default: '0};
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            c_q    <= c_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe: 2-stage main instance plus
// 1-stage and 32-stage instances for latency extremes.
module tb_addsub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid1;
    logic        in_valid32;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_ready;

    logic        in_ready, out_valid, carry, overflow, zero;
    logic [31:0] sum;
    logic        in_ready1, out_valid1, carry1, overflow1, zero1;
    logic [31:0] sum1;
    logic        in_ready32, out_valid32, carry32, overflow32, zero32;
    logic [31:0] sum32;

    int errors;
    int checks;

    addsub_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
    );

    addsub_pipe #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .carry(carry1), .overflow(overflow1), .zero(zero1)
    );

    addsub_pipe #(.WIDTH(32), .STAGES(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .carry(carry32), .overflow(overflow32), .zero(zero32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for one cycle, then wait out the 2-stage latency.
    task automatic drive_op(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        @(negedge clk);
        a = va; b = vb; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; in_valid32 = 1'b0;
        a = 32'h0; b = 32'h0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {carry, overflow, zero}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_carry_boundary();
        @(negedge clk);
        a = 32'h0000_FFFF; b = 32'h0000_0001; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cb_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cb_early_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cb_latency: got %b expected 1", out_valid); end
        checks++; if (sum !== 32'h0001_0000) begin errors++; $display("FAIL cb_sum: got %h expected 00010000", sum); end
        checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL cb_flags: got %b expected 000", {carry, overflow, zero}); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pos;
        logic [31:0] exp_neg;
`ifdef ADDSUB_SAT_EN
        exp_pos = 32'h7FFF_FFFF;
        exp_neg = 32'h8000_0000;
`else
        exp_pos = 32'h8000_0000;
        exp_neg = 32'h7FFF_FFFF;
`endif
        drive_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        checks++; if (sum !== exp_pos) begin errors++; $display("FAIL ovf_pos_sum: got %h expected %h", sum, exp_pos); end
        checks++; if ({carry, overflow, zero} !== 3'b010) begin errors++; $display("FAIL ovf_pos_flags: got %b expected 010", {carry, overflow, zero}); end
        drive_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        checks++; if (sum !== exp_neg) begin errors++; $display("FAIL ovf_neg_sum: got %h expected %h", sum, exp_neg); end
        checks++; if ({carry, overflow, zero} !== 3'b110) begin errors++; $display("FAIL ovf_neg_flags: got %b expected 110", {carry, overflow, zero}); end
    endtask

    task automatic test_subtract();
        drive_op(32'd5, 32'd5, 1'b1);
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL sub_eq_sum: got %h expected 00000000", sum); end
        checks++; if ({carry, overflow, zero} !== 3'b101) begin errors++; $display("FAIL sub_eq_flags: got %b expected 101", {carry, overflow, zero}); end
        drive_op(32'd3, 32'd5, 1'b1);
        checks++; if (sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg_sum: got %h expected fffffffe", sum); end
        checks++; if ({carry, overflow, zero} !== 3'b000) begin errors++; $display("FAIL sub_neg_flags: got %b expected 000", {carry, overflow, zero}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [31:0] te [8];
        logic        ts [8];
        logic [31:0] prev_sum;
        int          tx;
        int          rx;
        logic        saw_block;
        ta[0] = 32'h0000_0001; tb[0] = 32'h0000_0002; ts[0] = 1'b0; te[0] = 32'h0000_0003;
        ta[1] = 32'h0000_0010; tb[1] = 32'h0000_0003; ts[1] = 1'b1; te[1] = 32'h0000_000D;
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF; ts[2] = 1'b0; te[2] = 32'hFFFF_FFFE;
        ta[3] = 32'h1234_5678; tb[3] = 32'h1111_1111; ts[3] = 1'b0; te[3] = 32'h2345_6789;
        ta[4] = 32'h0001_0000; tb[4] = 32'h0000_0001; ts[4] = 1'b1; te[4] = 32'h0000_FFFF;
        ta[5] = 32'hAAAA_AAAA; tb[5] = 32'h5555_5555; ts[5] = 1'b0; te[5] = 32'hFFFF_FFFF;
        ta[6] = 32'h0000_0100; tb[6] = 32'h0000_0100; ts[6] = 1'b1; te[6] = 32'h0000_0000;
        ta[7] = 32'h0F0F_0F0F; tb[7] = 32'hF0F0_F0F1; ts[7] = 1'b0; te[7] = 32'h0000_0000;
        tx = 0; rx = 0; saw_block = 1'b0; prev_sum = 32'h0;
        for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (tx < 8);
            if (tx < 8) begin
                a = ta[tx]; b = tb[tx]; sub = ts[tx];
            end
            #1;
            if (cyc >= 5 && cyc <= 6) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== prev_sum) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b sum=%h expected valid=1 sum=%h", cyc, out_valid, sum, prev_sum);
                end
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (sum !== te[rx]) begin
                    errors++;
                    $display("FAIL stream_result%0d: got %h expected %h", rx, sum, te[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            prev_sum = sum;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rx != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", rx); end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL stream_backpressure: got %b expected 1", saw_block); end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        stale = 1'b0;
        @(negedge clk);
        a = 32'h0000_0011; b = 32'h0000_0022; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h0000_0033; b = 32'h0000_0044;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL rst_mid_sum: got %h expected 00000000", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got %b expected 0", stale); end
    endtask

    task automatic test_stage_extremes();
        int          lat1;
        int          lat32;
        logic [34:0] r1;
        logic [34:0] r32;
        lat1 = 0; lat32 = 0; r1 = '0; r32 = '0;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b1; in_valid32 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            in_valid1 = 1'b0; in_valid32 = 1'b0;
            #1;
            if (out_valid1 && lat1 == 0) begin
                lat1 = cyc; r1 = {sum1, carry1, overflow1, zero1};
            end
            if (out_valid32 && lat32 == 0) begin
                lat32 = cyc; r32 = {sum32, carry32, overflow32, zero32};
            end
        end
        checks++; if (lat1 != 1) begin errors++; $display("FAIL s1_latency: got %0d expected 1", lat1); end
        checks++; if (r1 !== {32'h0, 3'b101}) begin errors++; $display("FAIL s1_result: got %h expected %h", r1, {32'h0, 3'b101}); end
        checks++; if (lat32 != 32) begin errors++; $display("FAIL s32_latency: got %0d expected 32", lat32); end
        checks++; if (r32 !== {32'h0, 3'b101}) begin errors++; $display("FAIL s32_result: got %h expected %h", r32, {32'h0, 3'b101}); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_carry_boundary();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_stage_extremes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor for the static-pipeline MIPS datapath. It replaces the single-cycle 32-bit combinational add wherever the carry chain limits timing, including the EX-stage ALU add path and branch-target add. The carry chain is split into `STAGES` registered segments, and the block adds subtract mode, carry, signed-overflow and zero flags. A valid/ready handshake at both ends lets the CPU stall it.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Must be divisible by `STAGES`.
- `STAGES`, default 2: number of carry segments, which is also the number of pipeline register ranks. Valid range 1..`WIDTH`. Segment width is `SEG = WIDTH/STAGES`.

Ports (clock and reset first):
- `clk` in 1: rising-edge clock. One clock domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: an operand pair is presented this cycle.
- `in_ready` out 1: the block accepts the operand pair this cycle.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `sub` in 1: 1 computes a − b; 0 computes a + b.
- `out_valid` out 1: result fields are valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `sum` out `WIDTH`: result.
- `carry` out 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `overflow` out 1: signed overflow.
- `zero` out 1: `sum` is all zeros.

## Operation
- Effective operand: `b' = sub ? ~b : b`. Carry-in to segment 0 is `sub`.
- Stage k (k = 0..STAGES−1) adds bits `[k*SEG +: SEG]` of a and b', plus the carry registered by stage k−1.
  - Stage 0 uses `sub` as its carry-in.
  - Each stage registers its partial sum, the outgoing carry, the remaining upper operand bits, and the lower result bits already computed.
- Overflow is computed in the last stage: `a[MSB] == b'[MSB] && sum[MSB] != a[MSB]`.
- `zero` is the NOR of the final `sum`.
- Arithmetic wraps modulo 2^WIDTH unless the saturation option is compiled in (see Configuration).
- Each stage k has a valid bit `v[k]`. Stage k loads when `!v[k] || adv[k]`, where `adv[k]` means stage k+1 can load. For the last stage, `adv` is `out_ready`.
- `in_ready` equals the stage-0 load condition. It is combinational from `out_ready` through the valid chain; no bubble is required.
- `in_valid && in_ready` captures the operands. When a stage loads but its input is not valid, it loads a bubble (`v` = 0).
- `out_valid = v[STAGES−1]`. `sum`, `carry`, `overflow` and `zero` come straight from the last-stage registers.
- Data in a stage is held unchanged while that stage is stalled (valid and not advancing).

## Timing
- Latency: a transfer accepted in cycle n appears with `out_valid` = 1 in cycle n+STAGES when nothing stalls.
- Throughput: one operation per cycle while `out_ready` = 1.
- `STAGES=1`: a single register rank; result appears the cycle after acceptance.
- Full pipeline with `out_ready` = 1: `in_ready` = 1, so the oldest result leaves and a new operand enters in the same cycle.
- Full pipeline with `out_ready` = 0: `in_ready` = 0 and all outputs are held stable.
- Partially full pipeline with `out_ready` = 0: earlier stages keep advancing into empty slots, so bubbles are squeezed out.
- Reset (`rst_n` = 0 at a clock edge) takes effect at that edge, including mid-operation:
  - All `v[k]` and all data registers clear to 0.
  - Outputs reset to `out_valid`=0, `sum`=0, `carry`=0, `overflow`=0, `zero`=0.
  - `in_ready` reads 1 while the pipeline is empty.
  - In-flight operations are discarded; none are emitted after reset.
- `zero` is computed from the final stored `sum`, so it is 0 while the reset values are in place.

## Configuration
- `ADDSUB_SAT_EN` defined: on signed overflow, `sum` clamps to 0x7FF…F for a positive true result (`a[MSB]`=0) or 0x800…0 for a negative true result.
  - `overflow` still reads 1.
  - `carry` is unchanged (raw carry).
  - `zero` is computed from the clamped `sum`.
- `ADDSUB_SAT_EN` undefined: `sum` wraps. No clamp logic is synthesised.

## Test plan
- WIDTH=32, STAGES=2, `out_ready`=1: a=0x0000_FFFF, b=0x0000_0001, sub=0 -> two cycles later `sum`=0x0001_0000, carry=0, overflow=0, zero=0. This checks carry crossing the segment boundary.
- a=0x7FFF_FFFF, b=1, sub=0 -> `sum`=0x8000_0000 and overflow=1. With `ADDSUB_SAT_EN`, `sum`=0x7FFF_FFFF and overflow=1.
- a=5, b=5, sub=1 -> `sum`=0, zero=1, carry=1. Then a=3, b=5, sub=1 -> `sum`=0xFFFF_FFFE, carry=0, overflow=0.
- Stream 8 back-to-back random operations with `out_ready` held low for 3 cycles mid-stream:
  - `in_ready` drops once both stages are full.
  - Outputs are held stable during the stall.
  - Results emerge in order and match a reference model; none are lost or duplicated.
- Assert `rst_n`=0 for one cycle while 2 operations are in flight -> next cycle `out_valid`=0, `sum`=0, `in_ready`=1, and no stale result ever appears.
- STAGES=1 and STAGES=WIDTH (32): a=0xFFFF_FFFF, b=1 -> `sum`=0, carry=1, zero=1, arriving after 1 and 32 cycles respectively.
